// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states,
// instruction classes and datapath mux-select encodings.
package multicycle_controller_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned ST_W  = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_ILLEGAL
  } instr_class_e;

  localparam logic ADR_PC  = 1'b0;
  localparam logic ADR_ALU = 1'b1;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_opcode_classifier.sv
// Combinational opcode decode into an instruction class and immediate format;
// unsupported optional instructions are reported as illegal.
module opcode_classifier
  import multicycle_controller_pkg::*;
#(
  parameter bit SUPPORT_IMM_ALU = 1'b1,
  parameter bit SUPPORT_JAL     = 1'b1
) (
  input  logic [OP_W-1:0]  opcode,
  output instr_class_e     instr_class,
  output logic [SEL_W-1:0] imm_src
);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    imm_src     = IMM_I;
    case (opcode)
      OP_LOAD:   instr_class = CLS_LOAD;
      OP_STORE:  begin instr_class = CLS_STORE; imm_src = IMM_S; end
      OP_RTYPE:  instr_class = CLS_RTYPE;
      OP_ITYPE:  instr_class = SUPPORT_IMM_ALU ? CLS_ITYPE : CLS_ILLEGAL;
      OP_BRANCH: begin instr_class = CLS_BRANCH; imm_src = IMM_B; end
      OP_JAL:    begin instr_class = SUPPORT_JAL ? CLS_JAL : CLS_ILLEGAL; imm_src = IMM_J; end
      default:   instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V style datapath with memory
// handshake stalls and a sticky illegal-opcode flag.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit SUPPORT_IMM_ALU = 1'b1,
  parameter bit SUPPORT_JAL     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [SEL_W-1:0] result_src,
  output logic [SEL_W-1:0] alu_src_a,
  output logic [SEL_W-1:0] alu_src_b,
  output logic [SEL_W-1:0] alu_op,
  output logic [SEL_W-1:0] imm_src,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [ST_W-1:0]  state
);

  state_e       state_q, state_d;
  logic         illegal_q, illegal_d;
  instr_class_e instr_class;

  opcode_classifier #(
    .SUPPORT_IMM_ALU (SUPPORT_IMM_ALU),
    .SUPPORT_JAL     (SUPPORT_JAL)
  ) u_classifier (
    .opcode      (opcode),
    .instr_class (instr_class),
    .imm_src     (imm_src)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state selection; unused encodings fall back to FETCH.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_class)
          CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
          CLS_RTYPE:           state_d = S_EXECUTER;
          CLS_ITYPE:           state_d = S_EXECUTEI;
          CLS_BRANCH:          state_d = S_BEQ;
          CLS_JAL:             state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs; fetch strobes are masked while reset is held.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready & rst_n;
        pc_write   = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = ADR_ALU;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = ADR_ALU;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-level bench: two controllers (full and minimal option
// sets) are driven instruction by instruction and checked every cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_v [2];
  logic [1:0] mr_v, z_v;
  logic [1:0] pcw, adr, mw, irw, rw, ilo;
  logic [1:0] rs [2], sa [2], sb [2], aop [2], imm [2];
  logic [3:0] st [2];

  logic [6:0] cur_op [2];
  logic       mill [2];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_controller #(
      .SUPPORT_IMM_ALU (g == 0),
      .SUPPORT_JAL     (g == 0)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (op_v[g]),
      .zero       (z_v[g]),
      .mem_ready  (mr_v[g]),
      .pc_write   (pcw[g]),
      .adr_src    (adr[g]),
      .mem_write  (mw[g]),
      .ir_write   (irw[g]),
      .result_src (rs[g]),
      .alu_src_a  (sa[g]),
      .alu_src_b  (sb[g]),
      .alu_op     (aop[g]),
      .imm_src    (imm[g]),
      .reg_write  (rw[g]),
      .illegal_op (ilo[g]),
      .state      (st[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] obs(input int k);
    return {pcw[k], adr[k], mw[k], irw[k], rs[k], sa[k], sb[k], aop[k], imm[k], rw[k], ilo[k]};
  endfunction

  // Expected control word for a state, straight from the per-state output table.
  function automatic logic [15:0] exp_out(input int s, input logic mr, input logic zz,
                                          input logic [6:0] op, input logic ill, input logic rn);
    logic pw = 0, ad = 0, w = 0, ir = 0, r = 0;
    logic [1:0] res = 0, a = 0, b = 0, o = 0, im = 0;
    case (op)
      7'b0100011: im = 2'd1;
      7'b1100011: im = 2'd2;
      7'b1101111: im = 2'd3;
      default:    im = 2'd0;
    endcase
    case (s)
      0:  begin b = 2; res = 2; ir = mr & rn; pw = mr & rn; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  ad = 1;
      4:  begin res = 1; r = 1; end
      5:  begin ad = 1; w = 1; end
      6:  begin a = 2; o = 2; end
      7:  begin a = 2; b = 1; o = 2; end
      8:  r = 1;
      9:  begin a = 2; o = 1; pw = zz; end
      10: begin a = 1; b = 2; pw = 1; end
      default: ;
    endcase
    return {pw, ad, w, ir, res, a, b, o, im, r, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // One clock cycle: drive inputs, compare mid-cycle, advance past the edge.
  task automatic step(input int k, input int est, input logic mr, input logic zz);
    mr_v[k] = mr;
    z_v[k]  = zz;
    op_v[k] = cur_op[k];
    #4;
    check($sformatf("state_i%0d", k), 32'(st[k]), 32'(est));
    check($sformatf("ctl_i%0d_s%0d", k, est), 32'(obs(k)),
          32'(exp_out(est, mr, zz, cur_op[k], mill[k], 1'b1)));
    @(posedge clk);
    #1;
  endtask

  // Whole instruction: sf fetch stalls, sm stalls in the memory-access state.
  task automatic run_instr(input int k, input logic [6:0] op, input logic zz,
                           input int sf, input int sm);
    logic imm_ok = (k == 0);
    logic jal_ok = (k == 0);
    cur_op[k] = op;
    repeat (sf) step(k, 0, 1'b0, rb());
    step(k, 0, 1'b1, rb());
    step(k, 1, rb(), rb());
    case (op)
      7'b0000011: begin
        step(k, 2, rb(), rb());
        repeat (sm) step(k, 3, 1'b0, rb());
        step(k, 3, 1'b1, rb());
        step(k, 4, rb(), rb());
      end
      7'b0100011: begin
        step(k, 2, rb(), rb());
        repeat (sm) step(k, 5, 1'b0, rb());
        step(k, 5, 1'b1, rb());
      end
      7'b0110011: begin step(k, 6, rb(), rb()); step(k, 8, rb(), rb()); end
      7'b1100011: step(k, 9, rb(), zz);
      7'b0010011: if (imm_ok) begin step(k, 7, rb(), rb()); step(k, 8, rb(), rb()); end
                  else mill[k] = 1'b1;
      7'b1101111: if (jal_ok) begin step(k, 10, rb(), rb()); step(k, 8, rb(), rb()); end
                  else mill[k] = 1'b1;
      default:    mill[k] = 1'b1;
    endcase
    mr_v[k] = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [6];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    for (int k = 0; k < 2; k++) begin
      op_v[k] = 7'b0000011; cur_op[k] = 7'b0000011; mill[k] = 1'b0;
    end
    mr_v = 2'b11; z_v = 2'b00;
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_state_i%0d", k), 32'(st[k]), 32'd0);
      check($sformatf("rst_ctl_i%0d", k), 32'(obs(k)),
            32'(exp_out(0, 1'b1, 1'b0, 7'b0000011, 1'b0, 1'b0)));
    end
    #5;
    rst_n = 1'b1;
    mr_v  = 2'b00;

    // Directed: lw, sw with two write stalls, beq taken/not taken.
    run_instr(0, 7'b0000011, 1'b0, 0, 0);
    run_instr(0, 7'b0100011, 1'b0, 0, 2);
    run_instr(0, 7'b1100011, 1'b1, 0, 0);
    run_instr(0, 7'b1100011, 1'b0, 0, 0);
    // Directed: jal illegal without jal support, flag held across next lw.
    run_instr(1, 7'b1101111, 1'b0, 0, 0);
    run_instr(1, 7'b0000011, 1'b0, 1, 1);

    for (int n = 0; n < 200; n++) begin
      int k = int'($urandom_range(0, 1));
      int sel = int'($urandom_range(0, 6));
      logic [6:0] op = (sel == 6) ? 7'($urandom) : ops[sel];
      run_instr(k, op, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Reset mid-stall in MEMREAD after setting the illegal flag.
    run_instr(0, 7'b1111111, 1'b0, 0, 0);
    cur_op[0] = 7'b0000011;
    step(0, 0, 1'b1, 1'b0);
    step(0, 1, 1'b1, 1'b0);
    step(0, 2, 1'b1, 1'b0);
    step(0, 3, 1'b0, 1'b0);
    check("pre_rst_state", 32'(st[0]), 32'd3);
    #2;
    mr_v[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    mill[0] = 1'b0;
    mill[1] = 1'b0;
    check("async_rst_state", 32'(st[0]), 32'd0);
    check("async_rst_ctl", 32'(obs(0)),
          32'(exp_out(0, 1'b1, 1'b0, 7'b0000011, 1'b0, 1'b0)));
    @(posedge clk);
    #1;
    check("held_rst_state", 32'(st[0]), 32'd0);
    rst_n = 1'b1;
    mr_v[0] = 1'b0;
    run_instr(0, 7'b0000011, 1'b0, 0, 0);
    run_instr(0, 7'b0110011, 1'b0, 0, 0);
    step(0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter SUPPORT_IMM_ALU, default 1: when 1, I-type ALU ops (opcode 0010011) are decoded; when 0 they are illegal.
REQ-002 SHALL have parameter SUPPORT_JAL, default 1: when 1, jal (opcode 1101111) is decoded; when 0 it is illegal.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR and old-PC capture enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = data, 10 = ALU result.
- alu_src_a  out  2  A mux: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  B mux: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = decode by funct.
- imm_src  out  2  immediate format.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  sticky illegal-opcode flag.
- state  out  4  current FSM state, for debug.

Function
REQ-004 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; encodings 11-15 SHALL go to FETCH on the next edge.
REQ-005 SHALL drive every control output not listed for a state to 0; no output is ever X or Z.
REQ-006 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready; hold in FETCH while mem_ready=0, else go to DECODE.
REQ-007 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. Next state by opcode:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI (only if SUPPORT_IMM_ALU=1).
- 1100011 -> BEQ.
- 1101111 -> JAL (only if SUPPORT_JAL=1).
- any other opcode -> FETCH, with illegal_op set to 1.
REQ-008 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; next state is MEMREAD if opcode=0000011, else MEMWRITE.
REQ-009 MEMREAD: adr_src=1, result_src=00; hold while mem_ready=0, else go to MEMWB.
REQ-010 MEMWB: result_src=01, reg_write=1; next state is FETCH.
REQ-011 MEMWRITE: adr_src=1, result_src=00, mem_write=1, held asserted until mem_ready=1; then go to FETCH.
REQ-012 EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10; next state is ALUWB.
REQ-013 EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10; next state is ALUWB.
REQ-014 ALUWB: result_src=00, reg_write=1; next state is FETCH.
REQ-015 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; next state is FETCH.
REQ-016 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; next state is ALUWB.
REQ-017 imm_src SHALL be combinational from opcode in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, other -> 00.
REQ-018 With mem_ready tied to 1, CPI SHALL be: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4; each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
REQ-019 illegal_op SHALL be set on the edge leaving DECODE with an illegal opcode, and SHALL be cleared only by reset.

Reset
REQ-020 rst_n=0 SHALL immediately force state=FETCH and illegal_op=0, asynchronously, including mid-instruction and mid-stall.
REQ-021 During reset, outputs SHALL equal FETCH values, with ir_write=pc_write=0 regardless of mem_ready.
REQ-022 After rst_n deasserts, the first transition SHALL occur on the next rising clk edge.

Structure
REQ-023 A shared package SHALL hold the opcode constants, the state enum and the mux-select encodings.
REQ-024 One sub-module SHALL exist: opcode_classifier (combinational), producing instruction class and imm_src from opcode and the two parameters.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- lw (0000011), mem_ready=1: states 0,1,2,3,4,0; reg_write=1 only in cycle 5; result_src=01 there.
- sw (0100011), mem_ready low for 2 cycles in MEMWRITE: mem_write=1 for 3 cycles; then FETCH.
- beq with zero=1 gives pc_write=1 in BEQ; with zero=0, pc_write=0; each takes 3 cycles.
- SUPPORT_JAL=0, opcode 1101111: DECODE -> FETCH and illegal_op=1, held across the next lw.
- rst_n pulsed low while in MEMREAD: state=0 before the next edge; illegal_op=0; outputs show FETCH values with ir_write=0.
